// File: rtl/display_in.sv
// display_in: serial segment-frame receiver that deserializes an LSB-first
// 8*DIGITS-bit seven-segment frame and decodes it back to a BCD word.
// Ports: clk/reset (async, active-high), enable (edge qualifier), ser_in and
// frame_active (serial data plus strobe), and registered outputs: bcd_out,
// frame_valid, decode_error, framing_error and frame_count.
module display_in #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                ser_in,
   input  logic                frame_active,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                frame_valid,
   output logic                decode_error,
   output logic                framing_error,
   output logic [15:0]         frame_count
);
   localparam int FRAME_BITS = 8 * DIGITS;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam int IDX_W      = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);

   typedef enum logic [1:0] {SYNC, IDLE, SHIFT, DISCARD} state_t;

   state_t                state_q, state_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      bit_count_q, bit_count_d;
   logic [4*DIGITS-1:0]   bcd_q, bcd_d;
   logic                  frame_valid_q, frame_valid_d;
   logic                  decode_error_q, decode_error_d;
   logic                  framing_error_q, framing_error_d;
   logic [15:0]           frame_count_q, frame_count_d;

   logic [4*DIGITS-1:0]   dec_bcd;
   logic                  dec_err;
   logic [4:0]            dec;

   // Returns {illegal, digit}; the dp bit is ignored.
   function automatic logic [4:0] seg_decode(input logic [7:0] seg);
      logic [4:0] r;
      case (seg[6:0])
         7'h3F:   r = 5'h00;
         7'h06:   r = 5'h01;
         7'h5B:   r = 5'h02;
         7'h4F:   r = 5'h03;
         7'h66:   r = 5'h04;
         7'h6D:   r = 5'h05;
         7'h7D:   r = 5'h06;
         7'h07:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h6F:   r = 5'h09;
         default: r = 5'h1F;
      endcase
      return r;
   endfunction

   always_comb begin
      dec_bcd = '0;
      dec_err = 1'b0;
      dec     = '0;
      for (int i = 0; i < DIGITS; i++) begin
         dec                 = seg_decode(shift_q[8*i +: 8]);
         dec_bcd[4*i +: 4]   = dec[3:0];
         dec_err             = dec_err | dec[4];
      end
   end

   // State register and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= SYNC;
         shift_q         <= '0;
         bit_count_q     <= '0;
         bcd_q           <= '0;
         frame_valid_q   <= 1'b0;
         decode_error_q  <= 1'b0;
         framing_error_q <= 1'b0;
         frame_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         shift_q         <= shift_d;
         bit_count_q     <= bit_count_d;
         bcd_q           <= bcd_d;
         frame_valid_q   <= frame_valid_d;
         decode_error_q  <= decode_error_d;
         framing_error_q <= framing_error_d;
         frame_count_q   <= frame_count_d;
      end
   end

   // Next-state logic; a disabled edge leaves the state where it is.
   always_comb begin
      state_d = state_q;
      if (enable) begin
         case (state_q)
            SYNC:    if (!frame_active) state_d = IDLE;
            IDLE:    if (frame_active) state_d = SHIFT;
            SHIFT: begin
               if (frame_active) begin
                  if (bit_count_q == FULL) state_d = DISCARD;
               end else begin
                  state_d = IDLE;
               end
            end
            DISCARD: if (!frame_active) state_d = IDLE;
            default: state_d = SYNC;
         endcase
      end
   end

   // Datapath/output next values. Pulses default low, so a disabled edge
   // drops them while everything else holds.
   always_comb begin
      shift_d         = shift_q;
      bit_count_d     = bit_count_q;
      bcd_d           = bcd_q;
      frame_valid_d   = 1'b0;
      decode_error_d  = decode_error_q;
      framing_error_d = 1'b0;
      frame_count_d   = frame_count_q;
      if (enable) begin
         case (state_q)
            IDLE: begin
               if (frame_active) begin
                  shift_d     = '0;
                  shift_d[0]  = ser_in;
                  bit_count_d = CNT_W'(1);
               end
            end
            SHIFT: begin
               if (frame_active) begin
                  if (bit_count_q == FULL) begin
                     framing_error_d = 1'b1;
                  end else begin
                     shift_d[bit_count_q[IDX_W-1:0]] = ser_in;
                     bit_count_d = bit_count_q + CNT_W'(1);
                  end
               end else if (bit_count_q == FULL) begin
                  bcd_d          = dec_bcd;
                  frame_valid_d  = 1'b1;
                  decode_error_d = dec_err;
                  frame_count_d  = frame_count_q + 16'd1;
               end else begin
                  framing_error_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bcd_out       = bcd_q;
   assign frame_valid   = frame_valid_q;
   assign decode_error  = decode_error_q;
   assign framing_error = framing_error_q;
   assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_display_in.sv
module tb_display_in;
   logic        clk;
   logic        reset;
   logic        enable;
   logic        ser_in;
   logic        frame_active;
   logic [15:0] bcd_out;
   logic        frame_valid;
   logic        decode_error;
   logic        framing_error;
   logic [15:0] frame_count;

   int vectors;
   int miscompares;
   int fv_pulses;
   int fe_pulses;
   int both_high;
   int fv_base;
   int fe_base;

   display_in #(.DIGITS(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .ser_in        (ser_in),
      .frame_active  (frame_active),
      .bcd_out       (bcd_out),
      .frame_valid   (frame_valid),
      .decode_error  (decode_error),
      .framing_error (framing_error),
      .frame_count   (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   initial begin
      fv_pulses = 0;
      fe_pulses = 0;
      both_high = 0;
   end
   always @(negedge clk) begin
      if (frame_valid === 1'b1) fv_pulses = fv_pulses + 1;
      if (framing_error === 1'b1) fe_pulses = fe_pulses + 1;
      if (frame_valid === 1'b1 && framing_error === 1'b1) both_high = both_high + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle 1 time unit; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends a 32-bit frame LSB first; if pause_at >= 0, enable drops for 5
   // cycles right before that bit while ser_in/frame_active are held.
   task automatic send_frame(input logic [31:0] data, input int pause_at);
      for (int k = 0; k < 32; k++) begin
         ser_in       = data[k];
         frame_active = 1'b1;
         if (k == pause_at) begin
            enable = 1'b0;
            for (int p = 0; p < 5; p++) step();
            check("paused_no_valid", {31'd0, frame_valid}, 32'd0);
            enable = 1'b1;
         end
         step();
      end
      check("no_valid_before_low", {31'd0, frame_valid}, 32'd0);
      frame_active = 1'b0;
      ser_in       = 1'b0;
      step();
   endtask

   task automatic idle(input int n);
      frame_active = 1'b0;
      ser_in       = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b1;
      enable       = 1'b1;
      ser_in       = 1'b0;
      frame_active = 1'b0;
      step();
      step();
      check("rst_bcd", {16'd0, bcd_out}, 32'd0);
      check("rst_flags", {29'd0, frame_valid, decode_error, framing_error}, 32'd0);
      check("rst_count", {16'd0, frame_count}, 32'd0);
      reset = 1'b0;
      idle(2);

      // Good frame 0x1234.
      fv_base = fv_pulses;
      send_frame(32'h065B4F66, -1);
      check("good_valid", {31'd0, frame_valid}, 32'd1);
      check("good_bcd", {16'd0, bcd_out}, 32'h1234);
      check("good_derr", {31'd0, decode_error}, 32'd0);
      check("good_count", {16'd0, frame_count}, 32'd1);
      idle(3);
      check("good_one_pulse", fv_pulses - fv_base, 32'd1);

      // Illegal byte2 -> digit F.
      send_frame(32'h07007F6F, -1);
      check("bad_bcd", {16'd0, bcd_out}, 32'h7F89);
      check("bad_derr", {31'd0, decode_error}, 32'd1);
      check("bad_count", {16'd0, frame_count}, 32'd2);
      idle(3);
      check("bad_derr_hold", {31'd0, decode_error}, 32'd1);

      // dp bit set everywhere.
      send_frame(32'hBFBFBFBF, -1);
      check("dp_bcd", {16'd0, bcd_out}, 32'h0000);
      check("dp_derr", {31'd0, decode_error}, 32'd0);
      idle(3);

      send_frame(32'h6D7D077F, -1);
      check("f5678_bcd", {16'd0, bcd_out}, 32'h5678);
      check("f5678_count", {16'd0, frame_count}, 32'd4);
      idle(3);

      // Short frame: 20 high cycles.
      fv_base = fv_pulses;
      fe_base = fe_pulses;
      for (int i = 0; i < 20; i++) begin
         frame_active = 1'b1;
         ser_in       = i[0];
         step();
      end
      frame_active = 1'b0;
      step();
      check("short_fe", {31'd0, framing_error}, 32'd1);
      idle(3);
      check("short_fe_pulses", fe_pulses - fe_base, 32'd1);
      check("short_no_valid", fv_pulses - fv_base, 32'd0);
      check("short_bcd_kept", {16'd0, bcd_out}, 32'h5678);
      check("short_count_kept", {16'd0, frame_count}, 32'd4);
      send_frame(32'h065B4F66, -1);
      check("after_short_bcd", {16'd0, bcd_out}, 32'h1234);
      check("after_short_count", {16'd0, frame_count}, 32'd5);
      idle(3);

      // Over-long frame: 40 high cycles.
      fv_base = fv_pulses;
      fe_base = fe_pulses;
      for (int i = 0; i < 40; i++) begin
         frame_active = 1'b1;
         ser_in       = 1'b1;
         step();
         if (i == 31) check("long_fe_edge32", {31'd0, framing_error}, 32'd0);
         if (i == 32) check("long_fe_edge33", {31'd0, framing_error}, 32'd1);
      end
      idle(3);
      check("long_fe_pulses", fe_pulses - fe_base, 32'd1);
      check("long_no_valid", fv_pulses - fv_base, 32'd0);
      check("long_bcd_kept", {16'd0, bcd_out}, 32'h1234);
      send_frame(32'h6D7D077F, -1);
      check("after_long_bcd", {16'd0, bcd_out}, 32'h5678);
      check("after_long_count", {16'd0, frame_count}, 32'd6);
      idle(3);

      // Reset at bit 10 of a frame.
      for (int k = 0; k < 10; k++) begin
         frame_active = 1'b1;
         ser_in       = k[0];
         step();
      end
      reset = 1'b1;
      #1;
      check("midrst_bcd", {16'd0, bcd_out}, 32'd0);
      check("midrst_count", {16'd0, frame_count}, 32'd0);
      check("midrst_derr", {31'd0, decode_error}, 32'd0);
      step();
      reset = 1'b0;
      fv_base = fv_pulses;
      fe_base = fe_pulses;
      for (int k = 12; k < 32; k++) begin
         frame_active = 1'b1;
         ser_in       = k[0];
         step();
      end
      idle(3);
      check("midrst_no_valid", fv_pulses - fv_base, 32'd0);
      check("midrst_no_fe", fe_pulses - fe_base, 32'd0);
      check("midrst_count_after", {16'd0, frame_count}, 32'd0);

      // Enable dropped at bit 16.
      send_frame(32'h065B4F66, 16);
      check("en_valid", {31'd0, frame_valid}, 32'd1);
      check("en_bcd", {16'd0, bcd_out}, 32'h1234);
      check("en_count", {16'd0, frame_count}, 32'd1);
      idle(3);

      check("never_both_high", both_high, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/display_in.md
# display_in

Serial segment-frame receiver: the far end of the display serial link. It deserializes the 32-bit, LSB-first segment frame that the display output block shifts out alongside its `sending_data` strobe. It decodes each 8-bit segment pattern back to a BCD digit and presents the 16-bit BCD word with a one-cycle valid pulse and error flags. It sits on the same clock as the transmitter's serial clock, for loopback checking and for board-to-board display mirroring.

## Interface
- `DIGITS`, 4: digits per frame; frame length is 8*`DIGITS` bits.
- `clk` in 1: serial clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `enable` in 1: when 0, the edge is ignored and all state and outputs hold, except that `frame_valid` and `framing_error` drop to 0.
- `ser_in` in 1: serial data, bit 0 of the frame first.
- `frame_active` in 1: high for exactly 8*`DIGITS` consecutive cycles per frame; driven from the transmitter's `sending_data`.
- `bcd_out` out 4*`DIGITS`: last good frame; digit i is in `[4i+3:4i]`; reset 0.
- `frame_valid` out 1: one-cycle pulse when `bcd_out` updates; reset 0.
- `decode_error` out 1: valid with `frame_valid`; 1 if any byte was not a legal digit pattern; reset 0.
- `framing_error` out 1: one-cycle pulse on a short or over-long frame; reset 0.
- `frame_count` out 16: count of accepted frames, wraps 0xFFFF→0; reset 0.

## Operation
- Segment byte: bit0=a … bit6=g, bit7=dp, active-high.
- Legal patterns (bit7 masked): 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Any other value decodes to 0xF and sets `decode_error`.
- Frame byte i (bits 8i+7:8i) maps to digit i.
- FSM, only on enabled edges:
  - **SYNC** (reset state): go to IDLE on the first edge with `frame_active`=0. This prevents capturing a partial frame after reset.
  - **IDLE**: when `frame_active`=1, shift `ser_in` in as bit 0, set bit_count=1, go to SHIFT.
  - **SHIFT**, `frame_active`=1 and bit_count<8*`DIGITS`: shift in the next bit and increment bit_count.
  - **SHIFT**, `frame_active`=1 and bit_count=8*`DIGITS` (overrun): pulse `framing_error`, go to DISCARD.
  - **SHIFT**, `frame_active`=0 and bit_count=8*`DIGITS`: load decoded `bcd_out`, pulse `frame_valid`, set `decode_error`, increment `frame_count`, go to IDLE.
  - **SHIFT**, `frame_active`=0 and bit_count<8*`DIGITS`: pulse `framing_error`, go to IDLE; `bcd_out` is unchanged.
  - **DISCARD**: go to IDLE on the first edge with `frame_active`=0; nothing is captured.
- Shift register: each new bit enters at index bit_count, so the data is LSB-first.
- A decoded frame that has `decode_error` set still updates `bcd_out` and is still counted.
- `decode_error` holds its value until the next `frame_valid`.

## Timing
- Bit k (0-based) is sampled on the (k+1)-th rising edge with `frame_active`=1. This matches the transmitter, whose `data_out` is registered one cycle behind its counter, so the bit and strobe are aligned.
- Latency: `frame_valid`, `bcd_out`, `decode_error` and `frame_count` update on the first edge with `frame_active` low after bit 8*`DIGITS`-1, i.e. one cycle after the last data bit.
- All outputs are registered.
- Back-to-back frames need at least one low cycle of `frame_active` between them. The transmitter provides more than 120 low cycles.
- `framing_error` and `frame_valid` are never high in the same cycle.
- `reset` asserted mid-frame: outputs clear at once; the FSM restarts in SYNC and discards the remainder of the frame in flight.
- `enable` low mid-frame: the frame freezes, bit_count is held, and the frame resumes when `enable` returns.

## Test plan
- **Good frame.** After reset plus 2 low cycles, send a frame for BCD 0x1234: bytes byte0=0x66 (4), byte1=0x4F (3), byte2=0x5B (2), byte3=0x06 (1), sent as 32 LSB-first bits. Required: exactly one `frame_valid`, `bcd_out`=0x1234, `decode_error`=0, `frame_count`=1.
- **Bad pattern.** Send byte2=0x00 with the other bytes encoding 9, 8, 7. Required: `bcd_out`=0x7F89, `decode_error`=1, `frame_count` increments.
- **dp ignored.** Send all four bytes as 0xBF. Required: `bcd_out`=0x0000, `decode_error`=0.
- **Short frame.** Hold `frame_active` high for 20 cycles. Required: one `framing_error` pulse, no `frame_valid`, `bcd_out` unchanged. A following good frame decodes correctly.
- **Over-long frame.** Hold `frame_active` high for 40 cycles. Required: `framing_error` on the 33rd high edge, no `frame_valid`, DISCARD until low. The next good frame is accepted.
- **Reset and enable.** Assert `reset` at bit 10: all outputs are 0 immediately. With `frame_active` still high after release, no capture occurs until it goes low. Separately, drop `enable` for 5 cycles at bit 16 while holding `ser_in`/`frame_active`: the frame completes with the correct value.
